// File: rtl/core_regfile_wb_if.sv
// Result/issue/query bundle between the execute stages and the register file write controller.
interface core_regfile_wb_if #(
    parameter int unsigned XLEN = 64
);
    // Port A: in-order pipeline results
    logic            a_valid;
    logic            a_ready;
    logic [4:0]      a_rd;
    logic [XLEN-1:0] a_wdata;

    // Port B: long-latency results
    logic            b_valid;
    logic            b_ready;
    logic [4:0]      b_rd;
    logic [XLEN-1:0] b_wdata;

    // Long-latency issue and hazard queries
    logic            iss_valid;
    logic            iss_ready;
    logic [4:0]      iss_rd;
    logic [4:0]      q_rs1_addr;
    logic [4:0]      q_rs2_addr;
    logic            q_rs1_busy;
    logic            q_rs2_busy;

    // Register file write port
    logic            rd_wen;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_wdata;

    modport master (
        output a_valid, a_rd, a_wdata,
        output b_valid, b_rd, b_wdata,
        output iss_valid, iss_rd, q_rs1_addr, q_rs2_addr,
        input  a_ready, b_ready, iss_ready, q_rs1_busy, q_rs2_busy,
        input  rd_wen, rd_addr, rd_wdata
    );

    modport slave (
        input  a_valid, a_rd, a_wdata,
        input  b_valid, b_rd, b_wdata,
        input  iss_valid, iss_rd, q_rs1_addr, q_rs2_addr,
        output a_ready, b_ready, iss_ready, q_rs1_busy, q_rs2_busy,
        output rd_wen, rd_addr, rd_wdata
    );
endinterface

// File: rtl/core_regfile_wb.sv
// Register file write-side controller: arbitrates pipeline (A) and buffered
// long-latency (B) results onto one write port and tracks outstanding
// long-latency destinations in a busy scoreboard.
module core_regfile_wb #(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned B_DEPTH    = 2,
    parameter int unsigned STARVE_LIM = 4
) (
    input  logic              g_clk,
    input  logic              g_resetn,
    core_regfile_wb_if.slave  bus
);

    localparam int unsigned PTR_W = $clog2(B_DEPTH);
    localparam int unsigned CNT_W = 4;
    localparam int unsigned NREG  = 32;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] wdata;
    } b_entry_t;

    b_entry_t           fifo_q [B_DEPTH];
    logic [PTR_W:0]     wr_ptr_q;
    logic [PTR_W:0]     wr_ptr_d;
    logic [PTR_W:0]     rd_ptr_q;
    logic [PTR_W:0]     rd_ptr_d;
    logic [CNT_W-1:0]   starve_cnt_q;
    logic [CNT_W-1:0]   starve_cnt_d;
    logic [NREG-1:0]    busy_q;
    logic [NREG-1:0]    busy_d;
    logic               rd_wen_q;
    logic               rd_wen_d;
    logic [4:0]         rd_addr_q;
    logic [4:0]         rd_addr_d;
    logic [XLEN-1:0]    rd_wdata_q;
    logic [XLEN-1:0]    rd_wdata_d;

    logic               fifo_empty;
    logic               fifo_full;
    logic               starve;
    logic               pop;
    logic               push;
    logic               a_fire;
    logic               iss_fire;
    b_entry_t           head;

    // FIFO status, arbitration and handshake readies
    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
        head       = fifo_q[rd_ptr_q[PTR_W-1:0]];
        starve     = (starve_cnt_q >= CNT_W'(STARVE_LIM)) && !fifo_empty;
        // A has priority unless B has been starved long enough
        pop        = !fifo_empty && (starve || !bus.a_valid);
        push       = bus.b_valid && !fifo_full;
        a_fire     = bus.a_valid && !starve;
        bus.iss_ready = (bus.iss_rd == 5'd0) || !busy_q[bus.iss_rd] ||
                        (pop && (head.rd == bus.iss_rd));
        iss_fire   = bus.iss_valid && bus.iss_ready;
    end

    assign bus.a_ready    = !starve;
    assign bus.b_ready    = !fifo_full;
    assign bus.q_rs1_busy = busy_q[bus.q_rs1_addr];
    assign bus.q_rs2_busy = busy_q[bus.q_rs2_addr];
    assign bus.rd_wen     = rd_wen_q;
    assign bus.rd_addr    = rd_addr_q;
    assign bus.rd_wdata   = rd_wdata_q;

    // Next-state: pointers, starve counter, write port, scoreboard
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        starve_cnt_d = starve_cnt_q;
        rd_wen_d     = 1'b0;
        rd_addr_d    = rd_addr_q;
        rd_wdata_d   = rd_wdata_q;
        busy_d       = busy_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
        end

        // Counts cycles a waiting B head is passed over; saturates
        if (fifo_empty || pop) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != {CNT_W{1'b1}}) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end

        if (pop) begin
            rd_addr_d  = head.rd;
            rd_wdata_d = head.wdata;
            rd_wen_d   = (head.rd != 5'd0);
        end else if (a_fire) begin
            rd_addr_d  = bus.a_rd;
            rd_wdata_d = bus.a_wdata;
            rd_wen_d   = (bus.a_rd != 5'd0);
        end

        // Clear first so a same-cycle issue to that register keeps it busy
        if (pop) begin
            busy_d[head.rd] = 1'b0;
        end
        if (iss_fire && (bus.iss_rd != 5'd0)) begin
            busy_d[bus.iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // FIFO storage; contents are only meaningful between the pointers
    always_ff @(posedge g_clk) begin
        if (push) begin
            fifo_q[wr_ptr_q[PTR_W-1:0]] <= '{rd: bus.b_rd, wdata: bus.b_wdata};
        end
    end

    // State registers
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            starve_cnt_q <= '0;
            busy_q       <= '0;
            rd_wen_q     <= 1'b0;
            rd_addr_q    <= '0;
            rd_wdata_q   <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            starve_cnt_q <= starve_cnt_d;
            busy_q       <= busy_d;
            rd_wen_q     <= rd_wen_d;
            rd_addr_q    <= rd_addr_d;
            rd_wdata_q   <= rd_wdata_d;
        end
    end

endmodule

// File: doc/core_regfile_wb.md
Name: core_regfile_wb

Overview:
- Write-side controller for the core register file. Produces the single rd_wen/rd_addr/rd_wdata write port.
- Arbitrates between two result sources:
  - Port A: in-order pipeline results (ALU/CSR).
  - Port B: long-latency results (load/mul/div), buffered in a small FIFO.
- Keeps a 1-bit-per-register busy scoreboard for outstanding long-latency writes. Issue logic uses it for RAW/WAW stalls.

Parameters:
- XLEN, 64, data width of write data.
- B_DEPTH, 2, port B FIFO depth. Power of two, >= 2.
- STARVE_LIM, 4, consecutive cycles a non-empty B FIFO may lose arbitration before B gets priority. Range 1..15.

Ports:
- g_clk  in  1  core clock, rising edge
- g_resetn  in  1  asynchronous active-low reset
- a_valid  in  1  pipeline result valid
- a_ready  out  1  pipeline result accepted
- a_rd  in  5  pipeline destination register
- a_wdata  in  XLEN  pipeline result data
- b_valid  in  1  long-latency result valid
- b_ready  out  1  B FIFO not full
- b_rd  in  5  long-latency destination register
- b_wdata  in  XLEN  long-latency result data
- iss_valid  in  1  long-latency op issuing, marks iss_rd busy
- iss_ready  out  1  issue permitted (iss_rd not busy)
- iss_rd  in  5  destination of issuing op
- q_rs1_addr  in  5  hazard query address 1
- q_rs2_addr  in  5  hazard query address 2
- q_rs1_busy  out  1  q_rs1_addr has outstanding write
- q_rs2_busy  out  1  q_rs2_addr has outstanding write
- rd_wen  out  1  register file write enable
- rd_addr  out  5  register file write address
- rd_wdata  out  XLEN  register file write data

Behaviour:
- Clock/reset: one clock, g_clk. Reset is asynchronous, active-low, on g_resetn.
- Reset values:
  - rd_wen=0, rd_addr=0, rd_wdata=0.
  - All busy bits 0. FIFO empty. Starve counter 0.
  - Consequently b_ready=1, iss_ready=1, a_ready=1, q_*_busy=0.
- Handshakes: valid/ready on A, B and issue. A transfer occurs when valid && ready on the rising edge. Sources must hold payload stable while valid && !ready.
- FIFO:
  - b_ready = !full. Push on b_valid && b_ready.
  - Push and pop in the same cycle are allowed when not full.
  - When full, no push that cycle, even if a pop occurs.
  - No pass-through: B data always spends at least 1 cycle in the FIFO.
- Arbitration, per cycle:
  - Default priority is A. a_ready=1 unless starve is active.
  - starve = (starve counter >= STARVE_LIM) && FIFO non-empty.
  - When starve: a_ready=0 and the FIFO head is popped.
  - Otherwise the FIFO head is popped only when !a_valid.
  - Starve counter increments when the FIFO is non-empty and the head is not popped. Clears on any pop or when the FIFO is empty.
- Write output (registered, latency 1):
  - The winner's rd/wdata are registered into rd_addr/rd_wdata.
  - rd_wen=1 the following cycle, only if the winning rd != 0.
  - If no winner, rd_wen=0. rd_addr/rd_wdata hold their last values.
- Scoreboard:
  - Set: iss_valid && iss_ready && iss_rd!=0 sets busy[iss_rd].
  - Clear: a FIFO pop clears busy[head.rd] on the same edge that registers rd_wen.
  - Port A never touches the scoreboard.
  - Same-cycle set and clear of the same register: set wins, bit stays 1.
  - busy[0] is constant 0.
- iss_ready = (iss_rd==0) || !busy[iss_rd] || (pop this cycle && head.rd==iss_rd).
- Queries: q_rsN_busy = busy[q_rsN_addr], combinational, with no bypass of same-cycle clear or set. The next cycle the register file's own rd forwarding supplies the data.
- Boundary cases:
  - B entry with rd=0: accepted, popped normally, no write, no scoreboard change.
  - B entry whose rd is not busy: written normally; the clear is a no-op.
  - Reset mid-operation discards FIFO contents and all busy bits. In-flight writes are lost.

Test Plan:
- Reset then idle 5 cycles -> rd_wen=0, b_ready=1, iss_ready=1, q_rs1_busy=0 throughout.
- A: a_valid=1, a_rd=5, a_wdata=0x1234 for 1 cycle -> next cycle rd_wen=1, rd_addr=5, rd_wdata=0x1234. Then a_rd=0 -> rd_wen=0.
- Issue iss_rd=7 -> q_rs1_addr=7 reads busy=1; a second issue with iss_rd=7 gets iss_ready=0. B push rd=7, data=0xAA with A idle -> write 0xAA to x7 at cycle push+2; busy clears at the same edge.
- A held valid continuously and B pushes rd=3 -> A wins 4 cycles, then a_ready=0 for 1 cycle and x3 is written. Starve counter returns to 0.
- Push 2 B entries while A is busy -> b_ready=0. A third push is held until the first pop; all three are written in order.
- Issue rd=9 in the same cycle that the B head rd=9 pops -> iss_ready=1 and busy[9] stays 1. Assert g_resetn=0 mid-stream -> all busy bits clear and the FIFO empties immediately.
